// File: rtl/vga_pkg.sv
// Shared video timing definitions: default 640x480@60 raster numbers, coordinate
// width and the stage-0 sync/active bundle used by the timing generator.
package vga_pkg;

    localparam int COORD_W = 10;
    localparam int FRAME_W = 16;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [FRAME_W-1:0] frame_t;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
    } stage_t;

    function automatic int h_tot(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_tot(int act, int fp, int sync, int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to sprite engines, mixer and DAC pins.
interface vga_timing_gen_if;
    import vga_pkg::*;

    coord_t spx;
    coord_t spy;
    logic   frame_start;
    frame_t frame_cnt;
    logic   active;
    logic   vga_hs;
    logic   vga_vs;
    logic   vga_blank;
    logic   vga_sync;

    modport master (
        output spx, spy, frame_start, frame_cnt,
        output active, vga_hs, vga_vs, vga_blank, vga_sync
    );

    modport slave (
        input spx, spy, frame_start, frame_cnt,
        input active, vga_hs, vga_vs, vga_blank, vga_sync
    );

endinterface

// File: rtl/vga_timing_gen_sig_delay.sv
// D-stage registered delay line; every stage resets to RST_VAL so the output is
// at its idle level throughout reset and until real data has propagated.
module sig_delay #(
    parameter int             W       = 1,
    parameter int             D       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [D-1:0][W-1:0] pipe_q, pipe_d;

    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = din;
        for (int i = 1; i < D; i++) pipe_d[i] = pipe_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pipe_q <= {D{RST_VAL}};
        else       pipe_q <= pipe_d;
    end

    assign dout = pipe_q[D-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel/line counters, frame pulse/counter, and sync/active
// delayed to line up with the mixer's registered RGB.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE_DLY = 2
) (
    input  logic              clk,
    input  logic              reset,
    vga_timing_gen_if.master  vif
);

    localparam int     H_TOT  = h_tot(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int     V_TOT  = v_tot(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam coord_t H_LAST = coord_t'(H_TOT - 1);
    localparam coord_t V_LAST = coord_t'(V_TOT - 1);
    localparam int     HS_BEG = H_ACTIVE + H_FP;
    localparam int     HS_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int     VS_BEG = V_ACTIVE + V_FP;
    localparam int     VS_END = V_ACTIVE + V_FP + V_SYNC;
    localparam stage_t STAGE_IDLE = '{act: 1'b0, hs: ~SYNC_POL, vs: ~SYNC_POL};

    if (PIPE_DLY < 1 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be within 1..4");
    end
    if (H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_bad_tot
        $error("vga_timing_gen: raster totals exceed coordinate width");
    end

    coord_t hcnt_q, hcnt_d;
    coord_t vcnt_q, vcnt_d;
    logic   frame_start_q, frame_start_d;
    frame_t frame_cnt_q, frame_cnt_d;
    logic   line_end, frame_end;
    stage_t stage0, stage_dly;

    always_comb begin
        line_end      = (hcnt_q == H_LAST);
        frame_end     = line_end && (vcnt_q == V_LAST);
        hcnt_d        = line_end ? '0 : hcnt_q + coord_t'(1);
        vcnt_d        = vcnt_q;
        if (line_end) vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + coord_t'(1);
        // Pulse lands in the cycle the counters show (0,0); reset's (0,0) is not a wrap.
        frame_start_d = frame_end;
        frame_cnt_d   = frame_end ? frame_cnt_q + frame_t'(1) : frame_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Polarity is folded in before the delay line so the pins come straight off flops.
    always_comb begin
        stage0.act = (int'(hcnt_q) < H_ACTIVE) && (int'(vcnt_q) < V_ACTIVE);
        stage0.hs  = ((int'(hcnt_q) >= HS_BEG) && (int'(hcnt_q) < HS_END)) ? SYNC_POL : ~SYNC_POL;
        stage0.vs  = ((int'(vcnt_q) >= VS_BEG) && (int'(vcnt_q) < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    sig_delay #(
        .W       ($bits(stage_t)),
        .D       (PIPE_DLY),
        .RST_VAL (STAGE_IDLE)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .din   (stage0),
        .dout  (stage_dly)
    );

    assign vif.spx         = hcnt_q;
    assign vif.spy         = vcnt_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_cnt   = frame_cnt_q;
    assign vif.active      = stage_dly.act;
    assign vif.vga_hs      = stage_dly.hs;
    assign vif.vga_vs      = stage_dly.vs;
    assign vif.vga_blank   = ~stage_dly.act;
    assign vif.vga_sync    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a reduced raster (15x8, PIPE_DLY=2) for line/frame timing and a
// 1x1 raster (PIPE_DLY=4) that wraps frame_cnt within 65536 clocks.
module tb_vga_timing_gen;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    vga_timing_gen_if vif();
    vga_timing_gen_if sif();

    // H: 8/2/3/2 -> 15 clk/line, hs0 on hcnt 10..12. V: 4/1/2/1 -> 8 lines, vs0 on vcnt 5..6.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIPE_DLY(2)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .vif   (vif)
    );

    vga_timing_gen #(
        .H_ACTIVE(1), .H_FP(0), .H_SYNC(0), .H_BP(0),
        .V_ACTIVE(1), .V_FP(0), .V_SYNC(0), .V_BP(0),
        .SYNC_POL(1'b0), .PIPE_DLY(4)
    ) u_small (
        .clk   (clk),
        .reset (reset),
        .vif   (sif)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int act_n = 0, hs_n = 0, vs_n = 0, fs_n = 0, clash_n = 0;
    bit found;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_spx",    32'(vif.spx), 0);
        chk("rst_spy",    32'(vif.spy), 0);
        chk("rst_active", 32'(vif.active), 0);
        chk("rst_hs",     32'(vif.vga_hs), 1);
        chk("rst_vs",     32'(vif.vga_vs), 1);
        chk("rst_blank",  32'(vif.vga_blank), 1);
        chk("rst_fs",     32'(vif.frame_start), 0);
        chk("rst_fcnt",   32'(vif.frame_cnt), 0);
        chk("vga_sync",   32'(vif.vga_sync), 0);

        reset = 1'b0;  // released at negedge: this sample is cycle 0
        for (int c = 0; c <= 65536; c++) begin
            if (c > 0) @(negedge clk);
            case (c)
                0: begin
                    chk("c0_spx", 32'(vif.spx), 0);
                    chk("c0_spy", 32'(vif.spy), 0);
                    chk("c0_active", 32'(vif.active), 0);
                    chk("c0_fs", 32'(vif.frame_start), 0);
                    chk("s_c0_fs", 32'(sif.frame_start), 0);
                end
                1: begin
                    chk("c1_spx", 32'(vif.spx), 1);
                    chk("c1_active", 32'(vif.active), 0);
                    chk("c1_blank", 32'(vif.vga_blank), 1);
                    chk("s_c1_fs", 32'(sif.frame_start), 1);
                    chk("s_c1_fcnt", 32'(sif.frame_cnt), 1);
                end
                2: begin
                    chk("c2_active", 32'(vif.active), 1);
                    chk("c2_blank", 32'(vif.vga_blank), 0);
                    chk("c2_hs", 32'(vif.vga_hs), 1);
                end
                3:   chk("s_c3_active", 32'(sif.active), 0);
                4:   chk("s_c4_active", 32'(sif.active), 1);
                9:   chk("c9_active", 32'(vif.active), 1);
                10:  chk("c10_active", 32'(vif.active), 0);
                11:  chk("c11_hs", 32'(vif.vga_hs), 1);
                12:  chk("c12_hs", 32'(vif.vga_hs), 0);
                14: begin
                    chk("c14_hs", 32'(vif.vga_hs), 0);
                    chk("c14_spx", 32'(vif.spx), 14);
                    chk("c14_spy", 32'(vif.spy), 0);
                end
                15: begin
                    chk("c15_hs", 32'(vif.vga_hs), 1);
                    chk("c15_spx", 32'(vif.spx), 0);
                    chk("c15_spy", 32'(vif.spy), 1);
                end
                76:  chk("c76_vs", 32'(vif.vga_vs), 1);
                77:  chk("c77_vs", 32'(vif.vga_vs), 0);
                106: chk("c106_vs", 32'(vif.vga_vs), 0);
                107: chk("c107_vs", 32'(vif.vga_vs), 1);
                119: begin
                    chk("c119_spx", 32'(vif.spx), 14);
                    chk("c119_spy", 32'(vif.spy), 7);
                    chk("c119_fcnt", 32'(vif.frame_cnt), 0);
                end
                120: begin
                    chk("c120_spx", 32'(vif.spx), 0);
                    chk("c120_spy", 32'(vif.spy), 0);
                    chk("c120_fs", 32'(vif.frame_start), 1);
                    chk("c120_fcnt", 32'(vif.frame_cnt), 1);
                end
                121: chk("c121_fs", 32'(vif.frame_start), 0);
                122: begin
                    chk("frame_active_cnt", 32'(act_n), 32);
                    chk("frame_hs_low_cnt", 32'(hs_n), 24);
                    chk("frame_vs_low_cnt", 32'(vs_n), 30);
                    chk("frame_fs_cnt", 32'(fs_n), 1);
                    chk("active_in_sync", 32'(clash_n), 0);
                end
                240: begin
                    chk("c240_fs", 32'(vif.frame_start), 1);
                    chk("c240_fcnt", 32'(vif.frame_cnt), 2);
                end
                65535: chk("s_fcnt_max", 32'(sif.frame_cnt), 32'h0000_ffff);
                65536: chk("s_fcnt_wrap", 32'(sif.frame_cnt), 0);
                default: ;
            endcase
            if (c >= 2 && c < 122) begin
                act_n += int'(vif.active);
                hs_n  += int'(!vif.vga_hs);
                vs_n  += int'(!vif.vga_vs);
                fs_n  += int'(vif.frame_start);
                if (vif.active && (!vif.vga_hs || !vif.vga_vs)) clash_n++;
            end
        end

        // Park inside hsync and vsync, then hit reset between clock edges.
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (vif.spx == 13 && vif.spy == 6) found = 1'b1;
        end
        chk("seek_mid_frame", 32'(found), 1);
        chk("pre_rst_hs", 32'(vif.vga_hs), 0);
        chk("pre_rst_vs", 32'(vif.vga_vs), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_spx", 32'(vif.spx), 0);
        chk("async_spy", 32'(vif.spy), 0);
        chk("async_hs", 32'(vif.vga_hs), 1);
        chk("async_vs", 32'(vif.vga_vs), 1);
        chk("async_active", 32'(vif.active), 0);
        chk("async_blank", 32'(vif.vga_blank), 1);
        chk("async_fcnt", 32'(vif.frame_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        chk("r_c0_spx", 32'(vif.spx), 0);
        @(negedge clk);
        chk("r_c1_spx", 32'(vif.spx), 1);
        chk("r_c1_active", 32'(vif.active), 0);
        @(negedge clk);
        chk("r_c2_active", 32'(vif.active), 1);
        chk("r_c2_fs", 32'(vif.frame_start), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
